// File: rtl/interleaver_pkg.sv
// Shared encodings and size helpers for the multi-bank row/column interleaver.
package interleaver_pkg;

    localparam logic [1:0] BANK_EMPTY    = 2'd0;
    localparam logic [1:0] BANK_FILLING  = 2'd1;
    localparam logic [1:0] BANK_FULL     = 2'd2;
    localparam logic [1:0] BANK_DRAINING = 2'd3;

    localparam logic DIR_INTLV   = 1'b0;
    localparam logic DIR_DEINTLV = 1'b1;

    // Sideband carried alongside each output word through the skid buffer.
    typedef struct packed {
        logic last;
        logic user;
    } beat_side_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) width++;
        return width;
    endfunction

    function automatic int unsigned frame_words(input int unsigned rows, input int unsigned cols);
        return rows * cols;
    endfunction

    function automatic int unsigned addr_width(input int unsigned rows, input int unsigned cols);
        return clog2(rows * cols);
    endfunction

endpackage

// File: rtl/interleaver_addr_gen.sv
// Column-wise read address walker; strides through one column, then restarts at the next column offset.
module interleaver_addr_gen
    import interleaver_pkg::*;
#(
    parameter int unsigned ROW = 512,
    parameter int unsigned COL = 32,
    parameter int unsigned AW  = addr_width(ROW, COL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dir,
    input  logic          advance,
    output logic [AW-1:0] addr,
    output logic          last_c
);
    localparam int unsigned CW = clog2((ROW > COL) ? ROW : COL);

    logic [CW-1:0] inner, inner_next, outer, outer_next;
    logic [CW-1:0] inner_max, outer_max;
    logic [AW-1:0] base, base_next, addr_next, stride;

    // Deinterleave swaps the roles of rows and columns.
    always_comb begin
        stride    = AW'(COL);
        inner_max = CW'(ROW - 1);
        outer_max = CW'(COL - 1);
        if (dir == DIR_DEINTLV) begin
            stride    = AW'(ROW);
            inner_max = CW'(COL - 1);
            outer_max = CW'(ROW - 1);
        end
    end

    assign last_c = (inner == inner_max) && (outer == outer_max);

    always_comb begin
        inner_next = inner;
        outer_next = outer;
        base_next  = base;
        addr_next  = addr;
        if (advance) begin
            if (inner != inner_max) begin
                inner_next = inner + CW'(1);
                addr_next  = addr + stride;
            end else if (outer != outer_max) begin
                inner_next = '0;
                outer_next = outer + CW'(1);
                base_next  = base + AW'(1);
                addr_next  = base + AW'(1);
            end else begin
                inner_next = '0;
                outer_next = '0;
                base_next  = '0;
                addr_next  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inner <= '0;
            outer <= '0;
            base  <= '0;
            addr  <= '0;
        end else begin
            inner <= inner_next;
            outer <= outer_next;
            base  <= base_next;
            addr  <= addr_next;
        end
    end

endmodule

// File: rtl/interleaver_mb.sv
// Multi-bank bidirectional block interleaver: linear fill of a bank, column-wise drain
// through a 2-entry skid buffer, banks used round-robin.
module interleaver_mb
    import interleaver_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned ROW   = 512,
    parameter int unsigned COL   = 32,
    parameter int unsigned BANKS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_dir,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             frame_err
);
    localparam int unsigned N     = frame_words(ROW, COL);
    localparam int unsigned AW    = addr_width(ROW, COL);
    localparam int unsigned BW    = clog2(BANKS);
    localparam int unsigned DEPTH = BANKS << AW;

    logic [BANKS-1:0][1:0] bank_state, bank_state_next;
    logic [BANKS-1:0]      bank_dir, bank_dir_next;
    logic [BW-1:0]         wr_ptr, wr_ptr_next, rd_ptr, rd_ptr_next;
    logic [AW-1:0]         wr_cnt, wr_cnt_next;
    logic                  ready_next, err_next;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [AW-1:0]         rd_addr;
    logic                  rd_last;
    logic [1:0]            rd_state;
    logic                  accept, wr_last, issue, pop;

    logic [WIDTH-1:0]      out_data, out_data_next, skid_data, skid_data_next, rd_word;
    beat_side_t            out_side, out_side_next, skid_side, skid_side_next, rd_side;
    logic [1:0]            fifo_cnt, fifo_cnt_next;
    logic                  valid_next;

    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        return (p == BW'(BANKS - 1)) ? '0 : p + BW'(1);
    endfunction

    assign accept   = s_axis_tvalid && s_axis_tready;
    assign wr_last  = (wr_cnt == AW'(N - 1));
    assign rd_state = bank_state[rd_ptr];
    assign pop      = m_axis_tvalid && m_axis_tready;
    // Data lands in the skid buffer at the issuing edge, so a free slot is all a read needs.
    assign issue    = ((rd_state == BANK_FULL) || (rd_state == BANK_DRAINING)) && (fifo_cnt != 2'd2);

    interleaver_addr_gen #(
        .ROW (ROW),
        .COL (COL),
        .AW  (AW)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .dir     (bank_dir[rd_ptr]),
        .advance (issue),
        .addr    (rd_addr),
        .last_c  (rd_last)
    );

    // Bank lifecycle, pointers and write counter.
    always_comb begin
        bank_state_next = bank_state;
        bank_dir_next   = bank_dir;
        wr_ptr_next     = wr_ptr;
        wr_cnt_next     = wr_cnt;
        rd_ptr_next     = rd_ptr;
        if (accept) begin
            if (bank_state[wr_ptr] == BANK_EMPTY) begin
                bank_state_next[wr_ptr] = BANK_FILLING;
                bank_dir_next[wr_ptr]   = cfg_dir;
            end
            if (wr_last) begin
                bank_state_next[wr_ptr] = BANK_FULL;
                wr_cnt_next             = '0;
                wr_ptr_next             = ptr_inc(wr_ptr);
            end else begin
                wr_cnt_next = wr_cnt + AW'(1);
            end
        end
        if (issue) begin
            if (rd_last) begin
                bank_state_next[rd_ptr] = BANK_EMPTY;
                rd_ptr_next             = ptr_inc(rd_ptr);
            end else if (rd_state == BANK_FULL) begin
                bank_state_next[rd_ptr] = BANK_DRAINING;
            end
        end
        ready_next = (bank_state_next[wr_ptr_next] == BANK_EMPTY) ||
                     (bank_state_next[wr_ptr_next] == BANK_FILLING);
        err_next   = accept && (s_axis_tlast != wr_last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_state    <= {BANKS{BANK_EMPTY}};
            bank_dir      <= '0;
            wr_ptr        <= '0;
            wr_cnt        <= '0;
            rd_ptr        <= '0;
            s_axis_tready <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            bank_state    <= bank_state_next;
            bank_dir      <= bank_dir_next;
            wr_ptr        <= wr_ptr_next;
            wr_cnt        <= wr_cnt_next;
            rd_ptr        <= rd_ptr_next;
            s_axis_tready <= ready_next;
            frame_err     <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[{wr_ptr, wr_cnt}] <= s_axis_tdata;
    end

    assign rd_word = mem[{rd_ptr, rd_addr}];
    assign rd_side = beat_side_t'{last: rd_last, user: bank_dir[rd_ptr]};

    // Two-slot skid buffer: slot 0 is the output register, slot 1 absorbs one stalled read.
    always_comb begin
        fifo_cnt_next  = fifo_cnt;
        out_data_next  = out_data;
        out_side_next  = out_side;
        skid_data_next = skid_data;
        skid_side_next = skid_side;
        case (fifo_cnt)
            2'd0: begin
                if (issue) begin
                    out_data_next = rd_word;
                    out_side_next = rd_side;
                    fifo_cnt_next = 2'd1;
                end
            end
            2'd1: begin
                if (pop && issue) begin
                    out_data_next = rd_word;
                    out_side_next = rd_side;
                end else if (pop) begin
                    fifo_cnt_next = 2'd0;
                end else if (issue) begin
                    skid_data_next = rd_word;
                    skid_side_next = rd_side;
                    fifo_cnt_next  = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    out_data_next = skid_data;
                    out_side_next = skid_side;
                    fifo_cnt_next = 2'd1;
                end
            end
        endcase
        valid_next = (fifo_cnt_next != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_cnt      <= '0;
            out_data      <= '0;
            out_side      <= '0;
            skid_data     <= '0;
            skid_side     <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            fifo_cnt      <= fifo_cnt_next;
            out_data      <= out_data_next;
            out_side      <= out_side_next;
            skid_data     <= skid_data_next;
            skid_side     <= skid_side_next;
            m_axis_tvalid <= valid_next;
        end
    end

    assign m_axis_tdata = out_data;
    assign m_axis_tlast = out_side.last;
    assign m_axis_tuser = out_side.user;

endmodule

// File: tb/tb_interleaver_mb.sv
// Directed bench for interleaver_mb with a 4x3 matrix and two banks.
module tb_interleaver_mb;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned ROW   = 4;
    localparam int unsigned COL   = 3;
    localparam int unsigned BANKS = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_dir;
    logic [WIDTH-1:0] s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tlast;
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic             m_axis_tuser;
    logic             frame_err;

    int passed = 0;
    int total  = 0;
    int err_count = 0;
    int stall_err = 0;
    int ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random

    logic [7:0] out_data [$];
    logic       out_last [$];
    logic       out_user [$];
    logic [7:0] ilv [12] = '{8'd0, 8'd3, 8'd6, 8'd9, 8'd1, 8'd4, 8'd7, 8'd10, 8'd2, 8'd5, 8'd8, 8'd11};

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_last  = 1'b0;
    logic       prev_user  = 1'b0;
    logic [7:0] prev_data  = 8'd0;

    interleaver_mb #(
        .WIDTH (WIDTH),
        .ROW   (ROW),
        .COL   (COL),
        .BANKS (BANKS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_dir       (cfg_dir),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output capture, stall-stability tracking and frame_err pulse counting.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (prev_valid && !prev_ready &&
                (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
                 m_axis_tlast !== prev_last || m_axis_tuser !== prev_user))
                stall_err++;
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                out_data.push_back(m_axis_tdata);
                out_last.push_back(m_axis_tlast);
                out_user.push_back(m_axis_tuser);
            end
            if (frame_err === 1'b1) err_count++;
        end
        prev_valid = (m_axis_tvalid === 1'b1);
        prev_ready = (m_axis_tready === 1'b1);
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        prev_user  = m_axis_tuser;
    end

    task automatic clear_outputs();
        out_data.delete();
        out_last.delete();
        out_user.delete();
        err_count = 0;
        stall_err = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the word is accepted.
    task automatic send_word(input logic [7:0] d, input logic l, input logic dir);
        int guard = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        cfg_dir       = dir;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (s_axis_tready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (s_axis_tready !== 1'b1) begin
            total++;
            $display("FAIL send_timeout word %0d tready %b want 1", d, s_axis_tready);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input logic dir);
        for (int w = 0; w < 12; w++)
            send_word(dir ? 8'(base + ilv[w]) : 8'(base + 8'(w)), (w == 11), dir);
    endtask

    task automatic wait_outputs(input int n);
        int guard = 0;
        while (out_data.size() < n && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        if (out_data.size() < n) begin
            total++;
            $display("FAIL wait_outputs got %0d words want %0d", out_data.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (s_axis_tready !== 1'b0) $display("FAIL reset_s_tready got %b want 0", s_axis_tready); else passed++;
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_m_tvalid got %b want 0", m_axis_tvalid); else passed++;
        total++; if (m_axis_tdata !== 8'd0) $display("FAIL reset_m_tdata got %0h want 0", m_axis_tdata); else passed++;
        total++; if (m_axis_tlast !== 1'b0) $display("FAIL reset_m_tlast got %b want 0", m_axis_tlast); else passed++;
        total++; if (m_axis_tuser !== 1'b0) $display("FAIL reset_m_tuser got %b want 0", m_axis_tuser); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else passed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (s_axis_tready !== 1'b0) $display("FAIL reset_release_early got %b want 0", s_axis_tready); else passed++;
        @(negedge clk);
        total++; if (s_axis_tready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", s_axis_tready); else passed++;
    endtask

    task automatic test_interleave();
        clear_outputs();
        ready_mode = 1;
        @(posedge clk);
        #1;
        send_frame(8'd0, 1'b0);
        @(negedge clk);
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL intlv_latency_t1 got %b want 0", m_axis_tvalid); else passed++;
        @(negedge clk);
        total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'd0)
            $display("FAIL intlv_latency_t2 got valid %b data %0d want 1 0", m_axis_tvalid, m_axis_tdata); else passed++;
        wait_outputs(12);
        for (int k = 0; k < 12; k++) begin
            total++; if (out_data[k] !== ilv[k]) $display("FAIL intlv_data[%0d] got %0d want %0d", k, out_data[k], ilv[k]); else passed++;
            total++; if ({out_last[k], out_user[k]} !== {(k == 11), 1'b0})
                $display("FAIL intlv_side[%0d] got last %b user %b want %b 0", k, out_last[k], out_user[k], (k == 11)); else passed++;
        end
        total++; if (err_count !== 0) $display("FAIL intlv_frame_err got %0d want 0", err_count); else passed++;
    endtask

    task automatic test_deinterleave();
        clear_outputs();
        ready_mode = 1;
        @(posedge clk);
        #1;
        send_frame(8'd0, 1'b1);
        wait_outputs(12);
        for (int k = 0; k < 12; k++) begin
            total++; if (out_data[k] !== 8'(k)) $display("FAIL deintlv_data[%0d] got %0d want %0d", k, out_data[k], k); else passed++;
            total++; if ({out_last[k], out_user[k]} !== {(k == 11), 1'b1})
                $display("FAIL deintlv_side[%0d] got last %b user %b want %b 1", k, out_last[k], out_user[k], (k == 11)); else passed++;
        end
        total++; if (err_count !== 0) $display("FAIL deintlv_frame_err got %0d want 0", err_count); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] base;
        logic [7:0] exp;
        logic       dir;
        clear_outputs();
        ready_mode = 2;
        @(posedge clk);
        #1;
        for (int f = 0; f < 4; f++) send_frame(8'(16 * (f + 1)), 1'(f % 2));
        wait_outputs(48);
        repeat (20) @(negedge clk);
        total++; if (out_data.size() !== 48) $display("FAIL b2b_count got %0d want 48", out_data.size()); else passed++;
        for (int i = 0; i < 48; i++) begin
            base = 8'(16 * (i / 12 + 1));
            dir  = 1'((i / 12) % 2);
            exp  = dir ? 8'(base + 8'(i % 12)) : 8'(base + ilv[i % 12]);
            total++; if (out_data[i] !== exp) $display("FAIL b2b_data[%0d] got %0d want %0d", i, out_data[i], exp); else passed++;
            total++; if ({out_last[i], out_user[i]} !== {(i % 12 == 11), dir})
                $display("FAIL b2b_side[%0d] got last %b user %b want %b %b", i, out_last[i], out_user[i], (i % 12 == 11), dir); else passed++;
        end
        total++; if (stall_err !== 0) $display("FAIL b2b_stall_stable got %0d changes want 0", stall_err); else passed++;
        total++; if (err_count !== 0) $display("FAIL b2b_frame_err got %0d want 0", err_count); else passed++;
        ready_mode = 1;
    endtask

    task automatic test_backpressure();
        int hi   = 0;
        int rise = -1;
        logic [7:0] exp;
        clear_outputs();
        ready_mode = 0;
        @(posedge clk);
        #1;
        send_frame(8'd0, 1'b0);
        send_frame(8'd100, 1'b1);
        repeat (10) begin
            @(negedge clk);
            if (s_axis_tready === 1'b1) hi++;
        end
        total++; if (hi !== 0) $display("FAIL bp_tready_low got %0d high cycles want 0", hi); else passed++;
        total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'd0)
            $display("FAIL bp_stalled_head got valid %b data %0d want 1 0", m_axis_tvalid, m_axis_tdata); else passed++;
        @(posedge clk);
        #1;
        ready_mode = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rise < 0 && s_axis_tready === 1'b1) rise = i;
        end
        total++; if (rise !== 11) $display("FAIL bp_tready_return got cycle %0d want 11", rise); else passed++;
        wait_outputs(24);
        for (int i = 0; i < 24; i++) begin
            exp = (i < 12) ? ilv[i] : 8'(100 + i - 12);
            total++; if (out_data[i] !== exp) $display("FAIL bp_data[%0d] got %0d want %0d", i, out_data[i], exp); else passed++;
        end
        total++; if (out_data.size() !== 24) $display("FAIL bp_count got %0d want 24", out_data.size()); else passed++;
    endtask

    task automatic test_tlast_err();
        clear_outputs();
        ready_mode = 1;
        @(posedge clk);
        #1;
        for (int w = 0; w < 12; w++) begin
            send_word(8'(w), (w == 5), 1'b0);
            total++; if (frame_err !== ((w == 5) || (w == 11)))
                $display("FAIL tlast_err_pulse[%0d] got %b want %b", w, frame_err, ((w == 5) || (w == 11))); else passed++;
        end
        wait_outputs(12);
        repeat (4) @(negedge clk);
        total++; if (err_count !== 2) $display("FAIL tlast_err_count got %0d want 2", err_count); else passed++;
        for (int k = 0; k < 12; k++) begin
            total++; if (out_data[k] !== ilv[k]) $display("FAIL tlast_data[%0d] got %0d want %0d", k, out_data[k], ilv[k]); else passed++;
        end
        total++; if (out_last[11] !== 1'b1 || out_data.size() !== 12)
            $display("FAIL tlast_frame_close got last %b size %0d want 1 12", out_last[11], out_data.size()); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        clear_outputs();
        ready_mode = 1;
        @(posedge clk);
        #1;
        for (int w = 0; w < 7; w++) send_word(8'(50 + w), 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++; if (s_axis_tready !== 1'b0) $display("FAIL midrst_s_tready got %b want 0", s_axis_tready); else passed++;
        total++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_err} !== 4'b0000)
            $display("FAIL midrst_flags got %b want 0000", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_err}); else passed++;
        total++; if (m_axis_tdata !== 8'd0) $display("FAIL midrst_tdata got %0d want 0", m_axis_tdata); else passed++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (s_axis_tready !== 1'b1) $display("FAIL midrst_ready_return got %b want 1", s_axis_tready); else passed++;
        send_frame(8'd200, 1'b0);
        wait_outputs(12);
        repeat (20) @(negedge clk);
        total++; if (out_data.size() !== 12) $display("FAIL midrst_count got %0d want 12", out_data.size()); else passed++;
        for (int k = 0; k < 12; k++) begin
            total++; if (out_data[k] !== 8'(200 + ilv[k])) $display("FAIL midrst_data[%0d] got %0d want %0d", k, out_data[k], 200 + ilv[k]); else passed++;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        cfg_dir       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        test_reset();
        test_interleave();
        test_deinterleave();
        test_back_to_back();
        test_backpressure();
        test_tlast_err();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
